// File: rtl/descrypt_round_scheduler.sv
// rtl/descrypt_round_scheduler.sv - iterative DES round controller for the descrypt core
//
// Purpose:
//   Owns the L/R half-block registers and drives one shared f-function
//   datapath through 16 rounds per DES pass, ITERATIONS passes per job.
//   The block starts as all zeros. The pre-output block (before the final
//   permutation) comes back with the job tag on a valid/ready result port.
//
// Parameters:
//   ITERATIONS  DES passes per job (descrypt uses 25), legal range 1..255
//   TAG_W       width of the opaque job tag
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   job_valid  job offered                  job_ready  scheduler idle, can accept
//   job_tag    tag, captured on the job handshake
//   f_r        R half driven to the f datapath (the R register itself)
//   f_round    round index 0..15, used for subkey select
//   f_result   P(S(E_salt(f_r) ^ K[f_round])) from the f datapath
//   res_valid  result available             res_ready  consumer ready
//   res_l      L half of the pre-output block
//   res_r      R half of the pre-output block
//   res_tag    tag of the finished job
//   busy       job in flight (RUN, and ISSUE when the f path is pipelined)
//
// Configuration macro:
//   DESCRYPT_F_PIPE_EN - the f datapath holds one register stage. Each round
//   then takes an ISSUE cycle and a RUN cycle, and f_r/f_round are held
//   across both. When the macro is undefined, each round takes one cycle.

module descrypt_round_scheduler #(
  parameter int ITERATIONS = 25,
  parameter int TAG_W      = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [TAG_W-1:0] job_tag,
  output logic [31:0]      f_r,
  output logic [3:0]       f_round,
  input  logic [31:0]      f_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_l,
  output logic [31:0]      res_r,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

`ifdef DESCRYPT_F_PIPE_EN
  localparam bit F_PIPE = 1'b1;
`else
  localparam bit F_PIPE = 1'b0;
`endif

  localparam logic [7:0] ITER_LAST = 8'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A round starts in ISSUE only when the f path is registered.
  localparam state_t ROUND_START = F_PIPE ? S_ISSUE : S_RUN;

  state_t           state;
  logic [31:0]      l_q;
  logic [31:0]      r_q;
  logic [3:0]       round_q;
  logic [7:0]       iter_q;
  logic [TAG_W-1:0] tag_q;

  logic last_round;
  logic last_iter;

  assign last_round = (round_q == 4'd15);
  assign last_iter  = (iter_q == ITER_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      l_q       <= '0;
      r_q       <= '0;
      round_q   <= '0;
      iter_q    <= '0;
      tag_q     <= '0;
      job_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid && job_ready) begin
            // The descrypt job always encrypts the all-zero block.
            l_q       <= '0;
            r_q       <= '0;
            round_q   <= '0;
            iter_q    <= '0;
            tag_q     <= job_tag;
            job_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ROUND_START;
          end
        end

        S_ISSUE: begin
          // f_r/f_round stay put while the registered f stage computes.
          state <= S_RUN;
        end

        S_RUN: begin
          if (!last_round) begin
            l_q     <= r_q;
            r_q     <= l_q ^ f_result;
            round_q <= round_q + 4'd1;
          end else begin
            // Round 16 has no swap. The pass output feeds the next pass
            // directly, because FP and IP cancel between passes.
            l_q     <= l_q ^ f_result;
            round_q <= 4'd0;
            iter_q  <= iter_q + 8'd1;
          end

          if (last_round && last_iter) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end else begin
            state <= ROUND_START;
          end
        end

        S_DONE: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            job_ready <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          job_ready <= 1'b1;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign f_r     = r_q;
  assign f_round = round_q;
  assign res_l   = l_q;
  assign res_r   = r_q;
  assign res_tag = tag_q;

endmodule

// File: tb/tb_descrypt_round_scheduler.sv
// tb/tb_descrypt_round_scheduler.sv - randomized bench for descrypt_round_scheduler against a Feistel reference model
`timescale 1ns/1ps

module tb_descrypt_round_scheduler;

  localparam int ITER = 25;
`ifdef DESCRYPT_F_PIPE_EN
  localparam int CPR = 2;
`else
  localparam int CPR = 1;
`endif
  localparam int LAT = 16 * ITER * CPR;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_tag;
  logic [31:0] f_r;
  logic [3:0]  f_round;
  logic [31:0] f_result;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_l;
  logic [31:0] res_r;
  logic [7:0]  res_tag;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ktab [16];
  bit          stub_ones = 1'b0;
  logic [31:0] walk_r [16];

  always #5 CLK = ~CLK;

  descrypt_round_scheduler #(.ITERATIONS(ITER), .TAG_W(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_tag   (job_tag),
    .f_r       (f_r),
    .f_round   (f_round),
    .f_result  (f_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_l     (res_l),
    .res_r     (res_r),
    .res_tag   (res_tag),
    .busy      (busy)
  );

  // Stand-in f function: a nonlinear mix of R with a per-round key word.
  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [3:0] rnd);
    if (stub_ones) return 32'hFFFF_FFFF;
    return ({r[12:0], r[31:13]} ^ ktab[rnd]) + (r * 32'h9E37_79B1);
  endfunction

`ifdef DESCRYPT_F_PIPE_EN
  always @(posedge CLK) f_result <= f_model(f_r, f_round);
`else
  always_comb f_result = f_model(f_r, f_round);
`endif

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Textbook DES passes: a swap after every round, then undo the last swap.
  task automatic model_job(output logic [31:0] el, output logic [31:0] er);
    logic [31:0] l, r, t;
    l = '0;
    r = '0;
    for (int p = 0; p < ITER; p++) begin
      for (int n = 0; n < 16; n++) begin
        if (p == 0) walk_r[n] = r;
        t = l ^ f_model(r, 4'(n));
        l = r;
        r = t;
      end
      t = l;
      l = r;
      r = t;
    end
    el = l;
    er = r;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_job_ready"}, 64'(job_ready), 64'd1);
    check_val({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check_val({tag, "_busy"},      64'(busy),      64'd0);
    check_val({tag, "_res_tag"},   64'(res_tag),   64'd0);
    check_val({tag, "_f_round"},   64'(f_round),   64'd0);
    check_val({tag, "_res_lr"},    {res_l, res_r}, 64'd0);
  endtask

  // Called just after the job handshake edge. The expected walk of f_r and
  // f_round comes from the model. The task can abort the job with a reset
  // or hold the result while a second job is offered.
  task automatic await_result(input logic [31:0] el, input logic [31:0] er, input logic [7:0] tag,
                              input int abort_at, input bit hold);
    int cyc;
    bit seen;
    bit spurious;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc <= LAT + 8) begin
      if (cyc == abort_at) begin
        RST_N = 1'b0;
        #2;
        check_reset_vals("abort");
        @(posedge CLK); #1;
        RST_N = 1'b1;
        spurious = 1'b0;
        repeat (LAT + 8) begin
          @(posedge CLK); #1;
          if (res_valid || busy) spurious = 1'b1;
        end
        check_val("abort_no_result", 64'(spurious), 64'd0);
        check_val("abort_idle_ready", 64'(job_ready), 64'd1);
        return;
      end
      if (res_valid) begin
        seen = 1'b1;
      end else begin
        if (cyc < 16 * CPR) begin
          check_val("walk_f_round", 64'(f_round), 64'(cyc / CPR));
          check_val("walk_f_r",     64'(f_r),     64'(walk_r[cyc / CPR]));
          check_val("walk_busy",    64'(busy),    64'd1);
        end
        @(posedge CLK); #1;
        cyc++;
      end
    end
    check_val("res_seen", 64'(seen), 64'd1);
    if (!seen) return;
    check_val("latency", 64'(cyc), 64'(LAT));
    check_val("res_lr",  {res_l, res_r}, {el, er});
    check_val("res_tag", 64'(res_tag), 64'(tag));
    check_val("done_busy", 64'(busy), 64'd0);
    if (hold) begin
      job_valid = 1'b1;
      job_tag   = tag + 8'd1;
      for (int i = 0; i < 20; i++) begin
        @(posedge CLK); #1;
        check_val("hold_valid", 64'(res_valid), 64'd1);
        check_val("hold_ready", 64'(job_ready), 64'd0);
        check_val("hold_lr",    {res_l, res_r}, {el, er});
        check_val("hold_tag",   64'(res_tag), 64'(tag));
      end
    end
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
    check_val("release_valid", 64'(res_valid), 64'd0);
    check_val("release_ready", 64'(job_ready), 64'd1);
  endtask

  task automatic run_job(input logic [7:0] tag, input int abort_at, input bit hold);
    logic [31:0] el, er;
    model_job(el, er);
    check_val("offer_ready", 64'(job_ready), 64'd1);
    job_valid = 1'b1;
    job_tag   = tag;
    @(posedge CLK); #1;
    job_valid = 1'b0;
    await_result(el, er, tag, abort_at, hold);
    if (hold) begin
      // job_valid stayed high through the release, so the next edge takes the job.
      @(posedge CLK); #1;
      job_valid = 1'b0;
      check_val("second_accept", 64'(job_ready), 64'd0);
      await_result(el, er, tag + 8'd1, -1, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] ref_l, ref_r;
    RST_N     = 1'b0;
    job_valid = 1'b0;
    job_tag   = '0;
    res_ready = 1'b0;
    for (int i = 0; i < 16; i++) ktab[i] = $urandom;

    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals("reset");
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check_reset_vals("idle");

    // All-ones stub: each pass returns the zero block.
    stub_ones = 1'b1;
    run_job(8'hA5, -1, 1'b0);
    stub_ones = 1'b0;

    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 16; i++) ktab[i] = $urandom;
      run_job(8'($urandom), -1, 1'b0);
    end

    // Reset while idle with non-zero L/R and tag still held.
    RST_N = 1'b0;
    #2;
    check_reset_vals("idle_rst");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check_reset_vals("idle_rst_rel");

    for (int i = 0; i < 16; i++) ktab[i] = $urandom;
    run_job(8'h3C, -1, 1'b1);

    // Abort mid-job, then the same job must still give the model result.
    model_job(ref_l, ref_r);
    run_job(8'h5A, 137, 1'b0);
    run_job(8'h5A, -1, 1'b0);
    check_val("rerun_lr", {res_l, res_r}, {ref_l, ref_r});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
